// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one small FIFO per result source, drained onto a
// single broadcast bus by a round-robin grant over the non-empty FIFOs.
module cdb_arbiter #(
   parameter int SRC_N = 3,
   parameter int DEPTH = 2
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 clear,
   input  logic [SRC_N-1:0]     src_en,
   input  logic [SRC_N*5-1:0]   src_tag,
   input  logic [SRC_N*32-1:0]  src_val,
   output logic [SRC_N-1:0]     src_full,
   output logic                 cdb_en,
   output logic [4:0]           cdb_tag,
   output logic [31:0]          cdb_val,
   output logic [1:0]           cdb_src,
   output logic                 ovf,
   output logic                 busy
);

   localparam int TAG_W = 5;
   localparam int VAL_W = 32;
   localparam int ENT_W = TAG_W + VAL_W;
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [ENT_W-1:0] mem_q [SRC_N][DEPTH];
   logic [ENT_W-1:0] mem_d [SRC_N][DEPTH];
   logic [CNT_W-1:0] cnt_q [SRC_N];
   logic [CNT_W-1:0] cnt_d [SRC_N];
   logic [PTR_W-1:0] head_q [SRC_N];
   logic [PTR_W-1:0] head_d [SRC_N];
   logic [PTR_W-1:0] tail_q [SRC_N];
   logic [PTR_W-1:0] tail_d [SRC_N];
   logic [1:0]       rr_q, rr_d;
   logic             cdb_en_q, cdb_en_d;
   logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
   logic [VAL_W-1:0] cdb_val_q, cdb_val_d;
   logic [1:0]       cdb_src_q, cdb_src_d;
   logic             ovf_q, ovf_d;

   logic             gnt_vld;
   logic [1:0]       gnt_idx;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Round-robin search starting at rr; first non-empty FIFO wins.
   always_comb begin
      logic [2:0] sum;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      sum     = '0;
      for (int k = 0; k < SRC_N; k++) begin
         sum = {1'b0, rr_q} + 3'(k);
         if (sum >= 3'(SRC_N)) sum = sum - 3'(SRC_N);
         if (!gnt_vld && cnt_q[sum[1:0]] != '0) begin
            gnt_vld = 1'b1;
            gnt_idx = sum[1:0];
         end
      end
   end

   always_comb begin
      logic pop;
      logic push_ok;
      mem_d     = mem_q;
      cnt_d     = cnt_q;
      head_d    = head_q;
      tail_d    = tail_q;
      rr_d      = rr_q;
      cdb_en_d  = cdb_en_q;
      cdb_tag_d = cdb_tag_q;
      cdb_val_d = cdb_val_q;
      cdb_src_d = cdb_src_q;
      ovf_d     = ovf_q;
      pop       = 1'b0;
      push_ok   = 1'b0;
      if (rdy_in) begin
         if (clear) begin
            for (int i = 0; i < SRC_N; i++) begin
               cnt_d[i]  = '0;
               head_d[i] = '0;
               tail_d[i] = '0;
            end
            rr_d     = '0;
            cdb_en_d = 1'b0;
         end else begin
            if (gnt_vld) begin
               cdb_en_d  = 1'b1;
               cdb_tag_d = mem_q[gnt_idx][head_q[gnt_idx]][ENT_W-1:VAL_W];
               cdb_val_d = mem_q[gnt_idx][head_q[gnt_idx]][VAL_W-1:0];
               cdb_src_d = gnt_idx;
               rr_d      = (gnt_idx == 2'(SRC_N - 1)) ? 2'd0 : gnt_idx + 2'd1;
            end else begin
               cdb_en_d = 1'b0;
            end
            // A full FIFO still accepts a push when it is being drained this edge.
            for (int i = 0; i < SRC_N; i++) begin
               pop     = gnt_vld && (gnt_idx == 2'(i));
               push_ok = src_en[i] && ((cnt_q[i] != CNT_W'(DEPTH)) || pop);
               if (src_en[i] && !push_ok) ovf_d = 1'b1;
               if (push_ok) begin
                  mem_d[i][tail_q[i]] = {src_tag[TAG_W*i +: TAG_W], src_val[VAL_W*i +: VAL_W]};
                  tail_d[i] = ptr_inc(tail_q[i]);
               end
               if (pop) head_d[i] = ptr_inc(head_q[i]);
               cnt_d[i] = cnt_q[i] + CNT_W'(push_ok) - CNT_W'(pop);
            end
         end
      end
   end

   // Payload storage carries no reset; occupancy is governed by the counts.
   always_ff @(posedge clk_in) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < SRC_N; i++) begin
            cnt_q[i]  <= '0;
            head_q[i] <= '0;
            tail_q[i] <= '0;
         end
         rr_q      <= '0;
         cdb_en_q  <= 1'b0;
         cdb_tag_q <= '0;
         cdb_val_q <= '0;
         cdb_src_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         rr_q      <= rr_d;
         cdb_en_q  <= cdb_en_d;
         cdb_tag_q <= cdb_tag_d;
         cdb_val_q <= cdb_val_d;
         cdb_src_q <= cdb_src_d;
         ovf_q     <= ovf_d;
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < SRC_N; i++) begin
         src_full[i] = (cnt_q[i] == CNT_W'(DEPTH));
         if (cnt_q[i] != '0) busy = 1'b1;
      end
   end

   assign cdb_en  = cdb_en_q;
   assign cdb_tag = cdb_tag_q;
   assign cdb_val = cdb_val_q;
   assign cdb_src = cdb_src_q;
   assign ovf     = ovf_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-based reference model compared after every
// clock edge, directed scenarios with literal expectations, then random traffic.
module tb_cdb_arbiter;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        clear;
   logic [2:0]  src_en;
   logic [14:0] src_tag;
   logic [95:0] src_val;
   logic [2:0]  src_full;
   logic        cdb_en;
   logic [4:0]  cdb_tag;
   logic [31:0] cdb_val;
   logic [1:0]  cdb_src;
   logic        ovf;
   logic        busy;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [36:0] mq [3][$];
   int          m_rr;
   logic        m_en;
   logic [4:0]  m_tag;
   logic [31:0] m_val;
   logic [1:0]  m_src;
   logic        m_ovf;

   cdb_arbiter #(.SRC_N(3), .DEPTH(DEPTH)) dut (
      .clk_in  (clk),
      .rst_in  (rst_in),
      .rdy_in  (rdy_in),
      .clear   (clear),
      .src_en  (src_en),
      .src_tag (src_tag),
      .src_val (src_val),
      .src_full(src_full),
      .cdb_en  (cdb_en),
      .cdb_tag (cdb_tag),
      .cdb_val (cdb_val),
      .cdb_src (cdb_src),
      .ovf     (ovf),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) mq[i].delete();
      m_rr = 0; m_en = 0; m_tag = 0; m_val = 0; m_src = 0; m_ovf = 0;
   endtask

   task automatic model_edge();
      int g;
      int idx;
      int pre [3];
      logic [36:0] ent;
      if (!rst_in) begin
         model_reset();
         return;
      end
      if (!rdy_in) return;
      if (clear) begin
         for (int i = 0; i < 3; i++) mq[i].delete();
         m_rr = 0;
         m_en = 0;
         return;
      end
      g = -1;
      for (int k = 0; k < 3; k++) begin
         idx = (m_rr + k) % 3;
         if (g < 0 && mq[idx].size() > 0) g = idx;
      end
      for (int i = 0; i < 3; i++) pre[i] = mq[i].size();
      if (g >= 0) begin
         ent   = mq[g].pop_front();
         m_en  = 1;
         m_tag = ent[36:32];
         m_val = ent[31:0];
         m_src = 2'(g);
         m_rr  = (g + 1) % 3;
      end else begin
         m_en = 0;
      end
      for (int i = 0; i < 3; i++) begin
         if (src_en[i]) begin
            if (pre[i] < DEPTH || g == i)
               mq[i].push_back({src_tag[5*i +: 5], src_val[32*i +: 32]});
            else
               m_ovf = 1;
         end
      end
   endtask

   task automatic compare_all();
      logic       exp_busy;
      logic [2:0] exp_full;
      exp_busy = 0;
      for (int i = 0; i < 3; i++) begin
         exp_full[i] = (mq[i].size() == DEPTH);
         if (mq[i].size() > 0) exp_busy = 1;
      end
      chk("cdb_en", 32'(cdb_en), 32'(m_en));
      chk("cdb_tag", 32'(cdb_tag), 32'(m_tag));
      chk("cdb_val", cdb_val, m_val);
      chk("cdb_src", 32'(cdb_src), 32'(m_src));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("src_full", 32'(src_full), 32'(exp_full));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic idle_in();
      src_en = 3'b000; clear = 1'b0; rdy_in = 1'b1;
   endtask

   initial begin
      rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0;
      src_en = '0; src_tag = '0; src_val = '0;
      model_reset();
      #1;
      chk("reset_cdb_en", 32'(cdb_en), 32'd0);
      chk("reset_ovf", 32'(ovf), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_full", 32'(src_full), 32'd0);
      cyc(); cyc();
      rst_in = 1'b1;

      // Single ALU result: broadcast two cycles after it is presented
      src_en = 3'b001; src_tag[4:0] = 5'd5; src_val[31:0] = 32'h0000_1234;
      cyc();
      idle_in();
      chk("single_c1_en", 32'(cdb_en), 32'd0);
      chk("single_c1_busy", 32'(busy), 32'd1);
      cyc();
      chk("single_c2_en", 32'(cdb_en), 32'd1);
      chk("single_c2_tag", 32'(cdb_tag), 32'd5);
      chk("single_c2_val", cdb_val, 32'h1234);
      chk("single_c2_src", 32'(cdb_src), 32'd0);
      chk("single_c2_busy", 32'(busy), 32'd0);
      cyc();
      chk("single_c3_en", 32'(cdb_en), 32'd0);

      // Return rr to 0, then all three sources at once
      clear = 1'b1; cyc(); idle_in();
      src_en = 3'b111; src_tag = {5'd3, 5'd2, 5'd1};
      src_val = {32'hC3C3_0003, 32'hB2B2_0002, 32'hA1A1_0001};
      cyc();
      idle_in();
      cyc();
      chk("rr_b1_src", 32'(cdb_src), 32'd0);
      chk("rr_b1_tag", 32'(cdb_tag), 32'd1);
      cyc();
      chk("rr_b2_src", 32'(cdb_src), 32'd1);
      chk("rr_b2_tag", 32'(cdb_tag), 32'd2);
      cyc();
      chk("rr_b3_src", 32'(cdb_src), 32'd2);
      chk("rr_b3_tag", 32'(cdb_tag), 32'd3);
      cyc();
      chk("rr_after_en", 32'(cdb_en), 32'd0);

      // LSB pushes 7..10 while ALU pushes every cycle
      for (int k = 0; k < 4; k++) begin
         src_en = 3'b011;
         src_tag = {5'd0, 5'(7 + k), 5'(20 + k)};
         src_val = {32'd0, 32'(32'h7000 + k), 32'(32'h2000 + k)};
         cyc();
         if (k == 1) chk("lsb_full_after_2", 32'(src_full[1]), 32'd1);
         if (k == 2) begin
            chk("lsb_pop_src", 32'(cdb_src), 32'd1);
            chk("lsb_pop_tag", 32'(cdb_tag), 32'd7);
            chk("lsb_third_kept", 32'(ovf), 32'd0);
         end
         if (k == 3) chk("lsb_drop_ovf", 32'(ovf), 32'd1);
      end
      idle_in();
      for (int k = 0; k < 6; k++) cyc();
      chk("ovf_sticky", 32'(ovf), 32'd1);

      // Clear with two entries buffered and a same-cycle push
      src_en = 3'b011; src_tag = {5'd0, 5'd12, 5'd11}; cyc();
      src_en = 3'b111; clear = 1'b1; cyc();
      idle_in();
      chk("clear_en", 32'(cdb_en), 32'd0);
      chk("clear_busy", 32'(busy), 32'd0);
      chk("clear_ovf_held", 32'(ovf), 32'd1);
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("clear_no_bcast", 32'(cdb_en), 32'd0);
      end

      // Freeze for three cycles with a pending entry
      src_en = 3'b001; src_tag[4:0] = 5'd15; src_val[31:0] = 32'hF00D; cyc();
      src_en = 3'b000; rdy_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("freeze_en", 32'(cdb_en), 32'd0);
         chk("freeze_busy", 32'(busy), 32'd1);
      end
      rdy_in = 1'b1; cyc();
      chk("resume_en", 32'(cdb_en), 32'd1);
      chk("resume_tag", 32'(cdb_tag), 32'd15);

      // Asynchronous reset between edges with two entries queued
      src_en = 3'b011; src_tag = {5'd0, 5'd22, 5'd21}; cyc();
      idle_in();
      #3 rst_in = 1'b0;
      #1;
      model_reset();
      chk("async_rst_en", 32'(cdb_en), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_ovf", 32'(ovf), 32'd0);
      @(negedge clk) rst_in = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("post_rst_no_stale", 32'(cdb_en), 32'd0);
      end

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         rst_in  = ($urandom_range(0, 199) != 0);
         rdy_in  = ($urandom_range(0, 99) >= 15);
         clear   = ($urandom_range(0, 99) < 4);
         src_en  = 3'($urandom_range(0, 7));
         src_tag = 15'($urandom);
         src_val = {$urandom, $urandom, $urandom};
         if (!rst_in) begin
            #1;
            model_reset();
            chk("rand_async_en", 32'(cdb_en), 32'd0);
         end
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter: SRC_N, 3, number of result sources (0=ALU, 1=LSB load, 2=branch unit); fixed at 3.
REQ-002 Parameter: DEPTH, 2, per-source buffer entries.
REQ-003 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_in  input  1  asynchronous, active-low reset.
REQ-005 rdy_in  input  1  global enable; low freezes all state.
REQ-006 clear  input  1  synchronous flush on misprediction.
REQ-007 src_en  input  3  per-source result valid, bit i = source i.
REQ-008 src_tag  input  15  ROB tag, 5 bits per source; source i at [5i+4:5i].
REQ-009 src_val  input  96  result, 32 bits per source; source i at [32i+31:32i].
REQ-010 src_full  output  3  bit i high when source i buffer holds DEPTH entries.
REQ-011 cdb_en  output  1  broadcast valid, one cycle per result.
REQ-012 cdb_tag  output  5  ROB tag of broadcast result.
REQ-013 cdb_val  output  32  broadcast data.
REQ-014 cdb_src  output  2  source index of current broadcast.
REQ-015 ovf  output  1  sticky flag, a push was dropped.
REQ-016 busy  output  1  high when any buffer is non-empty.

Function
REQ-017 Block SHALL hold one DEPTH-entry FIFO per source, each with a 2-bit count, a 1-bit head pointer and a 1-bit tail pointer; pointers wrap modulo DEPTH.
REQ-018 Push: when rdy_in=1 and clear=0 and src_en[i]=1 at an edge, {tag,val} SHALL enqueue into FIFO i.
REQ-019 src_full[i] and busy SHALL be combinational from the registered counts only.
REQ-020 Push to a FIFO with count=DEPTH SHALL be accepted only if that FIFO pops at the same edge; otherwise it is dropped, FIFO i is unchanged and ovf is set.
REQ-021 Selection SHALL be combinational round-robin over non-empty FIFOs.
  - Search order: rr, rr+1, rr+2 (mod 3).
  - rr is a 2-bit pointer holding values 0..2.
  - The first non-empty FIFO in that order is granted.
REQ-022 On a grant at an edge with rdy_in=1 and clear=0:
  - the granted FIFO's head pops;
  - cdb_en<=1; cdb_tag, cdb_val, cdb_src <= head entry and its index;
  - rr <= (grant+1) mod 3.
REQ-023 If no FIFO is non-empty at such an edge, cdb_en<=0; cdb_tag, cdb_val, cdb_src and rr SHALL hold.
REQ-024 Latency: a result presented in cycle k into an empty, ungranted-competition FIFO SHALL appear with cdb_en=1 in cycle k+2.
REQ-025 At most one broadcast per cycle; a source with pending entries SHALL be granted within 3 non-frozen cycles (starvation-free).
REQ-026 Simultaneous push and pop on one FIFO SHALL leave its count unchanged, and FIFO order SHALL be preserved.
REQ-027 rdy_in=0: all registers and outputs SHALL hold; pushes are ignored (not counted as overflow).
REQ-028 clear=1 with rdy_in=1 at an edge:
  - all counts and pointers <= 0; rr <= 0; cdb_en <= 0;
  - same-edge pushes are discarded, not flagged;
  - ovf holds.
REQ-029 clear SHALL take precedence over push, pop and grant.

Reset
REQ-030 rst_in low SHALL immediately, independent of clk_in, set:
  - all FIFO counts and pointers, and rr, to 0;
  - cdb_en=0, cdb_tag=0, cdb_val=0, cdb_src=0, ovf=0.
REQ-031 Reset asserted mid-operation SHALL discard all buffered results; the first edge after rst_in rises behaves as from the empty state.

Verification
REQ-032 Single ALU result, tag=5, val=0x0000_1234, in cycle 0 -> cdb_en=1, cdb_tag=5, cdb_val=0x1234, cdb_src=0 in cycle 2 only; busy low again from cycle 2.
REQ-033 All three sources push in the same cycle (tags 1,2,3), rr=0 -> broadcasts in consecutive cycles in order src 0,1,2; rr ends at 0.
REQ-034 LSB pushes tags 7,8,9 on consecutive cycles while ALU pushes every cycle:
  - src_full[1] rises after the second push;
  - third push dropped unless the LSB FIFO pops at that edge;
  - if dropped, ovf=1 and stays 1.
REQ-035 Two entries buffered plus a push in the cycle clear=1 -> next cycle cdb_en=0, busy=0, no further broadcasts; ovf unchanged.
REQ-036 rdy_in held low 3 cycles with a pending entry -> cdb outputs and counts frozen; broadcast resumes the cycle after rdy_in returns high.
REQ-037 rst_in pulled low between clock edges with two entries queued -> cdb_en=0 immediately and no stale tag is broadcast after release.
